// File: rtl/xulie_1110.sv
// -----------------------------------------------------------------------------
// xulie_1110 -- serial "1110" sequence detector (Moore machine)
//
// Watches one serial bit per rising clock edge and raises Dout for exactly
// one cycle once the terminating 0 of a 1-1-1-0 run has been sampled. A run
// of more than three 1s still counts as a match when the 0 finally arrives.
// Bits are never shared between two detections.
//
// Ports
//   reset : synchronous, active-high; forces the detector back to idle
//   clk   : single clock, all state changes on its rising edge
//   Din   : serial data bit, oldest bit first
//   Dout  : detection flag, one cycle wide, driven straight from a flop
// -----------------------------------------------------------------------------
module xulie_1110 (
    input  logic reset,
    input  logic clk,
    input  logic Din,
    output logic Dout
);

    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "11"
        S3 = 3'd3,  // "111" or a longer run of 1s
        S4 = 3'd4   // "1110" just completed
    } state_t;

    // Declaration initialisers keep the machine idle before the first reset
    // on targets and simulators that honour register power-up values.
    state_t state_r      = S0;
    state_t state_next_s;
    logic   dout_r       = 1'b0;
    logic   dout_next_s;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the three unused encodings fall back to S0.
    always_comb begin
        state_next_s = S0;
        case (state_r)
            S0: begin
                if (Din) begin
                    state_next_s = S1;
                end else begin
                    state_next_s = S0;
                end
            end
            S1: begin
                if (Din) begin
                    state_next_s = S2;
                end else begin
                    state_next_s = S0;
                end
            end
            S2: begin
                if (Din) begin
                    state_next_s = S3;
                end else begin
                    state_next_s = S0;
                end
            end
            S3: begin
                // Extra 1s keep the partial match alive.
                if (Din) begin
                    state_next_s = S3;
                end else begin
                    state_next_s = S4;
                end
            end
            S4: begin
                // A 1 here is the first bit of a fresh match; the 0 just
                // consumed is never reused.
                if (Din) begin
                    state_next_s = S1;
                end else begin
                    state_next_s = S0;
                end
            end
            default: begin
                state_next_s = S0;
            end
        endcase
    end

    // The flag flop tracks "next state is S4", so after each edge it equals
    // a decode of the state register while avoiding any decode glitches.
    always_comb begin
        dout_next_s = 1'b0;
        if (state_next_s == S4) begin
            dout_next_s = 1'b1;
        end else begin
            dout_next_s = 1'b0;
        end
    end

    // Registered detection flag, cleared by reset together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r <= 1'b0;
        end else begin
            dout_r <= dout_next_s;
        end
    end

    assign Dout = dout_r;

endmodule

// File: tb/tb_xulie_1110.sv
// -----------------------------------------------------------------------------
// Self-checking bench for xulie_1110. A reference model remembers the bits
// seen since the last reset or detection and flags a match whenever the four
// most recent of them read 1,1,1,0.
// -----------------------------------------------------------------------------
module tb_xulie_1110;

    logic clk;
    logic reset;
    logic Din;
    logic Dout;

    int checks;
    int errors;

    // Reference model state.
    logic [3:0] hist;
    int         nbits;
    logic       exp_dout;

    xulie_1110 dut (
        .reset (reset),
        .clk   (clk),
        .Din   (Din),
        .Dout  (Dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Model update for one rising edge.
    task automatic model_step(input logic r, input logic d);
        if (r) begin
            hist     = 4'b0000;
            nbits    = 0;
            exp_dout = 1'b0;
        end else begin
            hist  = {hist[2:0], d};
            nbits = nbits + 1;
            exp_dout = (nbits >= 4) && (hist == 4'b1110);
            if (exp_dout) begin
                nbits = 0;
                hist  = 4'b0000;
            end
        end
    endtask

    // Drive inputs (called just after a falling edge), clock once, check.
    task automatic step(input logic r, input logic d, input string tag, output logic obs);
        reset = r;
        Din   = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        obs = Dout;
        check(tag, Dout, exp_dout);
        @(negedge clk);
    endtask

    // Feed a string of '0'/'1' characters, returning the observed pulse count.
    task automatic run_bits(input string s, input string tag, output int pulses);
        logic o;
        pulses = 0;
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, (s[i] == "1") ? 1'b1 : 1'b0, tag, o);
            if (o === 1'b1) begin
                pulses++;
            end
        end
    endtask

    initial begin
        logic o;
        int   p;
        int   p2;

        checks   = 0;
        errors   = 0;
        hist     = 4'b0000;
        nbits    = 0;
        exp_dout = 1'b0;
        reset    = 1'b0;
        Din      = 1'b0;

        // No detection may be reported before the first reset.
        #1;
        check("power_up", Dout, 1'b0);
        @(negedge clk);

        // Reset held for several cycles keeps the flag low throughout.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i[0], "reset_hold", o);
        end

        // Basic match.
        run_bits("1110", "basic", p);
        check_int("basic_pulses", p, 1);
        run_bits("00", "basic_tail", p);
        check_int("basic_tail_pulses", p, 0);

        // Long run with an over-long string of 1s and a second match.
        step(1'b1, 1'b0, "reset_long", o);
        run_bits("00101111101110100", "long_run", p);
        check_int("long_run_pulses", p, 2);

        // Near misses.
        step(1'b1, 1'b0, "reset_near", o);
        run_bits("110", "near_110", p);
        run_bits("10", "near_10", p2);
        p = p + p2;
        run_bits("01111", "near_01111", p2);
        p = p + p2;
        check_int("near_pulses", p, 0);

        // Re-entry from the detected state.
        step(1'b1, 1'b0, "reset_reentry", o);
        run_bits("11101110", "reentry", p);
        check_int("reentry_pulses", p, 2);

        // Reset in the middle of a partial match discards it.
        step(1'b1, 1'b0, "reset_mid_pre", o);
        run_bits("111", "mid_prefix", p);
        step(1'b1, 1'b0, "mid_reset", o);
        run_bits("0", "mid_zero", p);
        check_int("mid_zero_pulses", p, 0);
        run_bits("1110", "mid_after", p);
        check_int("mid_after_pulses", p, 1);

        // Reset on the edge right after a detection clears the flag.
        step(1'b1, 1'b0, "reset_det_pre", o);
        run_bits("1110", "det_seq", p);
        check_int("det_seq_pulses", p, 1);
        step(1'b1, 1'b1, "det_reset", o);
        check("det_reset_low", o, 1'b0);
        run_bits("0", "det_after", p);
        check_int("det_after_pulses", p, 0);

        // Randomised traffic biased towards 1s, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 "random", o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
